// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller and its datapath:
// FSM states, opcode/function codes, mux selects and the decoded instruction class.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_MDWAIT = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;
  localparam logic [1:0] WB_HILO   = 2'b11;

  localparam logic [1:0] ASRC_PC    = 2'b00;
  localparam logic [1:0] ASRC_A     = 2'b01;
  localparam logic [1:0] ASRC_SHAMT = 2'b10;

  localparam logic [1:0] BSRC_B       = 2'b00;
  localparam logic [1:0] BSRC_FOUR    = 2'b01;
  localparam logic [1:0] BSRC_IMM     = 2'b10;
  localparam logic [1:0] BSRC_IMM_SH2 = 2'b11;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_HIGH = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;

  localparam logic [1:0] NPC_ALU    = 2'b00;
  localparam logic [1:0] NPC_JUMP   = 2'b01;
  localparam logic [1:0] NPC_REG    = 2'b10;
  localparam logic [1:0] NPC_ALUOUT = 2'b11;

  typedef struct packed {
    logic valid;
    logic r_alu;
    logic i_alu;
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic jump_link;
    logic jump_reg;
    logic jump_reg_link;
    logic md_mult;
    logic md_div;
    logic mf_hi;
    logic mf_lo;
  } instr_class_t;

  localparam int CLS_W = $bits(instr_class_t);

  function automatic logic is_md(instr_class_t c);
    return c.md_mult | c.md_div;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction-class decode: IR opcode/function fields to
// class one-hots plus the immediate extension mode and ALU operation.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  output logic [CLS_W-1:0] cls,
  output logic [1:0]       ext_op,
  output logic [2:0]       alu_ctrl
);

  instr_class_t c;

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    c        = '0;
    ext_op   = EXT_ZERO;
    alu_ctrl = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: c.r_alu = 1'b1;
          FN_SUBU: begin c.r_alu = 1'b1; alu_ctrl = ALU_SUB; end
          FN_SLL:  begin c.r_alu = 1'b1; alu_ctrl = ALU_SLL; end
          FN_JR:   c.jump_reg = 1'b1;
          FN_JALR: c.jump_reg_link = 1'b1;
          FN_MULT: c.md_mult = 1'b1;
          FN_DIV:  c.md_div = 1'b1;
          FN_MFHI: c.mf_hi = 1'b1;
          FN_MFLO: c.mf_lo = 1'b1;
          default: ;
        endcase
      end
      OP_ORI:   begin c.i_alu = 1'b1; alu_ctrl = ALU_OR; end
      OP_ADDIU: begin c.i_alu = 1'b1; ext_op = EXT_SIGN; end
      OP_LUI:   begin c.i_alu = 1'b1; ext_op = EXT_HIGH; alu_ctrl = ALU_OR; end
      OP_LW:    begin c.load = 1'b1; ext_op = EXT_SIGN; end
      OP_SW:    begin c.store = 1'b1; ext_op = EXT_SIGN; end
      OP_BEQ:   begin c.branch = 1'b1; ext_op = EXT_SIGN; alu_ctrl = ALU_SUB; end
      OP_J:     c.jump = 1'b1;
      OP_JAL:   c.jump_link = 1'b1;
      default:  ;
    endcase
    // valid is still 0 here, so this is the OR of all class bits
    c.valid = |c;
  end

  assign cls = c;

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB plus MDWAIT for
// mult/div, with memory wait states and combinational datapath controls.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] WbSel,
  output logic [1:0] ALU_Asrc,
  output logic [1:0] ALU_Bsrc,
  output logic [1:0] ExtOp,
  output logic [2:0] ALUctrl,
  output logic [1:0] nPC_sel,
  output logic       MDStart,
  output logic       MDOp,
  output logic       HiLoSel,
  output logic       busy
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  logic [CLS_W-1:0] cls_bits;
  instr_class_t     cls;
  logic [1:0]       dec_ext_op;
  logic [2:0]       dec_alu_ctrl;

  mc_decode u_decode (
    .op       (Op),
    .func     (func),
    .cls      (cls_bits),
    .ext_op   (dec_ext_op),
    .alu_ctrl (dec_alu_ctrl)
  );

  assign cls = instr_class_t'(cls_bits);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = REGDST_RT;
    WbSel       = WB_ALUOUT;
    ALU_Asrc    = ASRC_PC;
    ALU_Bsrc    = BSRC_B;
    ExtOp       = EXT_ZERO;
    ALUctrl     = ALU_ADD;
    nPC_sel     = NPC_ALU;
    MDStart     = 1'b0;
    MDOp        = 1'b0;
    HiLoSel     = 1'b0;
    busy        = 1'b0;

    // Reset is synchronous, so the outputs must be gated here to keep the reset cycle write-free
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          MemRead  = 1'b1;
          ALU_Bsrc = BSRC_FOUR;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = ST_DECODE;
          end
        end

        ST_DECODE: begin
          ALU_Bsrc = BSRC_IMM_SH2;
          ExtOp    = EXT_SIGN;
          state_d  = cls.valid ? ST_EXEC : ST_FETCH;
        end

        ST_EXEC: begin
          ExtOp   = dec_ext_op;
          ALUctrl = dec_alu_ctrl;
          HiLoSel = cls.mf_hi;
          state_d = ST_FETCH;
          if (cls.r_alu || cls.i_alu) begin
            ALU_Asrc = (dec_alu_ctrl == ALU_SLL) ? ASRC_SHAMT : ASRC_A;
            ALU_Bsrc = cls.r_alu ? BSRC_B : BSRC_IMM;
            state_d  = ST_WB;
          end
          if (cls.load || cls.store) begin
            ALU_Asrc = ASRC_A;
            ALU_Bsrc = BSRC_IMM;
            state_d  = ST_MEM;
          end
          if (cls.branch) begin
            ALU_Asrc    = ASRC_A;
            PCWriteCond = 1'b1;
            nPC_sel     = NPC_ALUOUT;
          end
          if (cls.jump || cls.jump_link) begin
            PCWrite = 1'b1;
            nPC_sel = NPC_JUMP;
          end
          if (cls.jump_reg || cls.jump_reg_link) begin
            PCWrite = 1'b1;
            nPC_sel = NPC_REG;
          end
          if (cls.jump_link || cls.jump_reg_link) begin
            RegWrite = 1'b1;
            RegDst   = cls.jump_link ? REGDST_RA : REGDST_RD;
            WbSel    = WB_PC;
          end
          if (is_md(cls)) begin
            MDStart  = 1'b1;
            MDOp     = cls.md_div;
            md_cnt_d = cls.md_div ? DIV_LOAD : MULT_LOAD;
            state_d  = (md_cnt_d == '0) ? ST_FETCH : ST_MDWAIT;
          end
          if (cls.mf_hi || cls.mf_lo) state_d = ST_WB;
        end

        ST_MEM: begin
          IorD     = 1'b1;
          ExtOp    = dec_ext_op;
          ALUctrl  = dec_alu_ctrl;
          MemRead  = cls.load;
          MemWrite = cls.store;
          if (mem_ready) state_d = cls.load ? ST_WB : ST_FETCH;
        end

        ST_WB: begin
          RegWrite = 1'b1;
          ExtOp    = dec_ext_op;
          ALUctrl  = dec_alu_ctrl;
          HiLoSel  = cls.mf_hi;
          RegDst   = (cls.r_alu || cls.mf_hi || cls.mf_lo) ? REGDST_RD : REGDST_RT;
          if (cls.load)                    WbSel = WB_MDR;
          else if (cls.mf_hi || cls.mf_lo) WbSel = WB_HILO;
          state_d  = ST_FETCH;
        end

        ST_MDWAIT: begin
          busy     = 1'b1;
          md_cnt_d = md_cnt_q - 1'b1;
          if (md_cnt_d == '0) state_d = ST_FETCH;
        end

        default: state_d = ST_FETCH;
      endcase
    end
  end

endmodule
